// File: rtl/sensor_cmd_pkg.sv
// sensor_cmd_pkg: command/reply codes, FSM state encoding and reply helpers for sensor_req_scheduler
package sensor_cmd_pkg;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_TEMP   = 8'h04;
  localparam logic [7:0] CMD_HUM    = 8'h05;
  localparam logic [7:0] RSP_OK     = 8'h08;
  localparam logic [7:0] RSP_TEMP   = 8'h09;
  localparam logic [7:0] RSP_HUM    = 8'h0A;
  localparam logic [7:0] RSP_FAULT  = 8'h1F;
  localparam logic [7:0] RSP_BADCMD = 8'hFF;
  localparam int TIMER_W = 26;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_CMD   = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT      = 3'd3;
  localparam logic [2:0] ST_EVAL      = 3'd4;
  localparam logic [2:0] ST_SEND_CODE = 3'd5;
  localparam logic [2:0] ST_SEND_VAL  = 3'd6;
  typedef struct packed {
    logic [7:0] code;
    logic [7:0] val;
  } reply_t;
  function automatic logic is_cmd(input logic [7:0] c);
    return c == CMD_STATUS || c == CMD_TEMP || c == CMD_HUM;
  endfunction
  // Reply for a completed read; only called with a command that passed is_cmd
  function automatic reply_t reply_for(input logic [7:0] c, input logic [7:0] temp, input logic [7:0] hum);
    reply_t r;
    r.code = c == CMD_STATUS ? RSP_OK : c == CMD_TEMP ? RSP_TEMP : RSP_HUM;
    r.val  = c == CMD_STATUS ? 8'h00 : c == CMD_TEMP ? temp : hum;
    return r;
  endfunction
  function automatic logic [7:0] crc_sum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction
endpackage

// File: rtl/sched_timer.sv
// sched_timer: clearable saturating cycle counter that flags when it reaches LIMIT
module sched_timer #(
  parameter int unsigned W     = 26,
  parameter int unsigned LIMIT = 1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam logic [W-1:0] LIM = W'(LIMIT);
  logic [W-1:0] cnt_q, cnt_d;
  assign hit_o = cnt_q == LIM;
  // Count while enabled, hold at the limit, restart from zero on clear
  always_comb cnt_d = clr_i ? '0 : (en_i && !hit_o) ? cnt_q + W'(1) : cnt_q;
  // Counter register
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sensor_req_scheduler.sv
// sensor_req_scheduler: frames host requests from UART rx, runs one sensor read, streams a 2-byte reply to UART tx.
// Optional CRC_CHECK_EN: reject sensor data whose crc byte is not the mod-256 sum of the four data bytes.
module sensor_req_scheduler
  import sensor_cmd_pkg::*;
#(
  parameter logic [7:0]  SENSOR_ADDR    = 8'h01,
  parameter int unsigned FRAME_TIMEOUT  = 5_000_000,
  parameter int unsigned SENSOR_TIMEOUT = 50_000_000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_byte_i,
  input  logic       tx_ready_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_byte_o,
  output logic       sensor_start_o,
  input  logic       sensor_done_i,
  input  logic       sensor_error_i,
  input  logic [7:0] hum_int_i,
  input  logic [7:0] hum_float_i,
  input  logic [7:0] temp_int_i,
  input  logic [7:0] temp_float_i,
  input  logic [7:0] crc_i,
  output logic       busy_o,
  output logic       drop_o
);
  logic [2:0] state_q, state_d;
  logic [7:0] cmd_q, cmd_d, code_q, code_d, val_q, val_d;
  logic [7:0] hum_q, temp_q;
  logic       start_q, drop_q;
  logic       frame_hit, sensor_hit, crc_bad, tmr_clr;
  reply_t     eval_rsp;

  assign tmr_clr        = state_d != state_q;
  assign busy_o         = state_q != ST_IDLE;
  assign tx_valid_o     = state_q == ST_SEND_CODE || state_q == ST_SEND_VAL;
  assign tx_byte_o      = state_q == ST_SEND_CODE ? code_q : state_q == ST_SEND_VAL ? val_q : 8'h00;
  assign sensor_start_o = start_q;
  assign drop_o         = drop_q;
  assign eval_rsp       = reply_for(cmd_q, temp_q, hum_q);

  sched_timer #(.W(TIMER_W), .LIMIT(FRAME_TIMEOUT)) u_frame_tmr (
    .clock_i(clock_i), .reset_i(reset_i), .clr_i(tmr_clr),
    .en_i(state_q == ST_GET_CMD), .hit_o(frame_hit)
  );
  sched_timer #(.W(TIMER_W), .LIMIT(SENSOR_TIMEOUT)) u_sensor_tmr (
    .clock_i(clock_i), .reset_i(reset_i), .clr_i(tmr_clr),
    .en_i(state_q == ST_WAIT), .hit_o(sensor_hit)
  );

`ifdef CRC_CHECK_EN
  logic [7:0] hum_f_q, temp_f_q, crc_q;
  assign crc_bad = crc_q != crc_sum(hum_q, hum_f_q, temp_q, temp_f_q);
  // Capture the extra bytes needed for the checksum alongside the reply data
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      hum_f_q  <= '0;
      temp_f_q <= '0;
      crc_q    <= '0;
    end else if (state_q == ST_WAIT && sensor_done_i) begin
      hum_f_q  <= hum_float_i;
      temp_f_q <= temp_float_i;
      crc_q    <= crc_i;
    end
`else
  logic unused_data;
  assign unused_data = ^{hum_float_i, temp_float_i, crc_i};
  assign crc_bad     = 1'b0;
`endif

  // Next-state and reply selection
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    code_d  = code_q;
    val_d   = val_q;
    case (state_q)
      ST_IDLE:
        if (rx_valid_i && rx_byte_i == SENSOR_ADDR) state_d = ST_GET_CMD;
      ST_GET_CMD:
        if (rx_valid_i) begin
          cmd_d   = rx_byte_i;
          state_d = is_cmd(rx_byte_i) ? ST_START : ST_SEND_CODE;
          code_d  = RSP_BADCMD;
          val_d   = 8'h00;
        end else if (frame_hit) state_d = ST_IDLE;
      ST_START:
        state_d = ST_WAIT;
      ST_WAIT:
        if (sensor_done_i) state_d = ST_EVAL;
        else if (sensor_error_i || sensor_hit) begin
          state_d = ST_SEND_CODE;
          code_d  = RSP_FAULT;
          val_d   = 8'h00;
        end
      ST_EVAL: begin
        state_d = ST_SEND_CODE;
        code_d  = crc_bad ? RSP_FAULT : eval_rsp.code;
        val_d   = crc_bad ? 8'h00 : eval_rsp.val;
      end
      ST_SEND_CODE:
        if (tx_ready_i) state_d = ST_SEND_VAL;
      ST_SEND_VAL:
        if (tx_ready_i) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // FSM, reply registers and one-cycle strobes
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      code_q  <= '0;
      val_q   <= '0;
      start_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      code_q  <= code_d;
      val_q   <= val_d;
      start_q <= state_q == ST_START;
      drop_q  <= rx_valid_i && state_q != ST_IDLE && state_q != ST_GET_CMD;
    end

  // Sensor data is sampled only on the done strobe of the request in flight
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      hum_q  <= '0;
      temp_q <= '0;
    end else if (state_q == ST_WAIT && sensor_done_i) begin
      hum_q  <= hum_int_i;
      temp_q <= temp_int_i;
    end
endmodule
